// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers.
// Write and read paths are independent FSMs; responses are always OKAY.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o
);

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          rdy_en;
  logic                          aw_held, w_held;
  logic [1:0]                    aw_sel_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [NBYTES-1:0]             w_strb_q;
  logic                          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]                    wr_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]             wr_strb;
  logic                          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READY is gated by a registered enable so it stays low through reset and
  // rises on the first clock edge afterwards, independent of any VALID input.
  assign S_AXI_AWREADY = rdy_en && ((w_state == W_IDLE) || ((w_state == W_WAIT) && !aw_held));
  assign S_AXI_WREADY  = rdy_en && ((w_state == W_IDLE) || ((w_state == W_WAIT) && !w_held));
  assign S_AXI_ARREADY = rdy_en && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_BRESP   = '0;
  assign S_AXI_RRESP   = '0;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign reg0_o = regs[0];
  assign reg1_o = regs[1];
  assign reg2_o = regs[2];
  assign reg3_o = regs[3];

  // Ready-enable: low in reset, high from the first edge after release
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rdy_en <= 1'b0;
    else                rdy_en <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  // Write next-state and commit decision; held channel data takes priority over live bus
  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    wr_sel      = aw_held ? aw_sel_q : S_AXI_AWADDR[3:2];
    wr_data     = w_held  ? w_data_q : S_AXI_WDATA;
    wr_strb     = w_held  ? w_strb_q : S_AXI_WSTRB;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end else if (aw_hs || w_hs) begin
          w_state_nxt = W_WAIT;
        end
      end
      W_WAIT: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP:  if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Capture AW and W independently; both are released by the commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_sel_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_sel_q <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Register bank: byte-strobed update on commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int unsigned k = 0; k < NBYTES; k++) begin
        if (wr_strb[k]) regs[wr_sel][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_state_nxt;
  end

  // Read next-state
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read data latch; sees the pre-commit value when a write lands on the same edge
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  S_AXI_RDATA <= '0;
    else if (ar_hs)      S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed self-checking bench for axi4lite_reg_slave.
module tb_axi4lite_reg_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 aclk = ~aclk;

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (aclk),
    .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .reg0_o       (reg0_o),
    .reg1_o       (reg1_o),
    .reg2_o       (reg2_o),
    .reg3_o       (reg3_o)
  );

  // Full write: AW and W together, then one-cycle BREADY. lat counts edges to BVALID.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic ok, output logic [1:0] resp, output int lat);
    int n;
    ok = 1'b1; n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 20) begin @(posedge aclk); #1; n++; end
    if (!(awready && wready)) ok = 1'b0;
    @(posedge aclk); #1; lat = 1;
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
    if (!bvalid) ok = 1'b0;
    resp = bresp;
    bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
  endtask

  // Full read with one-cycle RREADY. lat counts edges to RVALID.
  task automatic do_read(input logic [3:0] a, output logic ok, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    ok = 1'b1; n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!arready) ok = 1'b0;
    @(posedge aclk); #1; lat = 1;
    arvalid = 1'b0;
    while (!rvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
    if (!rvalid) ok = 1'b0;
    d = rdata; resp = rresp;
    rready = 1'b1; @(posedge aclk); #1; rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctl got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    tests_run++;
    if ({rdata, bresp, rresp} !== 36'h0) begin
      tests_failed++; $display("FAIL reset_data rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp);
    end
    tests_run++;
    if ({reg3_o, reg2_o, reg1_o, reg0_o} !== 128'h0) begin
      tests_failed++; $display("FAIL reset_regs got %h %h %h %h want 0", reg3_o, reg2_o, reg1_o, reg0_o);
    end
    aresetn = 1'b1;
    #1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b000) begin
      tests_failed++; $display("FAIL ready_before_edge got %b want 000", {awready, wready, arready});
    end
    @(posedge aclk); #1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++; $display("FAIL ready_after_edge got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic        ok;
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), 4'hF, ok, resp, lat);
      tests_run++;
      if (!ok || lat != 1 || resp !== 2'b00) begin
        tests_failed++; $display("FAIL write%0d ok=%b lat=%0d bresp=%b want ok=1 lat=1 bresp=00", i, ok, lat, resp);
      end
    end
    tests_run++;
    if ({reg3_o, reg2_o, reg1_o, reg0_o} !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      tests_failed++; $display("FAIL reg_outputs got %h %h %h %h want 4 3 2 1", reg3_o, reg2_o, reg1_o, reg0_o);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), ok, d, resp, lat);
      tests_run++;
      if (!ok || lat != 1 || d !== 32'(i + 1) || resp !== 2'b00) begin
        tests_failed++;
        $display("FAIL read%0d ok=%b lat=%0d rdata=%h rresp=%b want ok=1 lat=1 rdata=%h rresp=00", i, ok, lat, d, resp, 32'(i + 1));
      end
    end
  endtask

  task automatic test_strobe();
    logic        ok;
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    do_write(4'h4, 32'hAABBCCDD, 4'hF, ok, resp, lat);
    do_write(4'h4, 32'h11223344, 4'h5, ok, resp, lat);
    do_read(4'h4, ok, d, resp, lat);
    tests_run++;
    if (!ok || d !== 32'hAA22CC44) begin
      tests_failed++; $display("FAIL strobe ok=%b rdata=%h want AA22CC44", ok, d);
    end
  endtask

  task automatic test_split_channels();
    int cnt;
    // W three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        tests_failed++; $display("FAIL w_first_wait%0d wready,awready,bvalid=%b want 010", i, {wready, awready, bvalid});
      end
      if (i < 2) begin @(posedge aclk); #1; end
    end
    awaddr = 4'h8; awvalid = 1'b1;
    @(posedge aclk); #1; awvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || reg2_o !== 32'h12345678) begin
      tests_failed++; $display("FAIL w_first_commit bvalid=%b reg2=%h want 1 12345678", bvalid, reg2_o);
    end
    cnt = 1; bready = 1'b1;
    repeat (4) begin @(posedge aclk); #1; if (bvalid) cnt++; end
    bready = 1'b0;
    tests_run++;
    if (cnt != 1) begin
      tests_failed++; $display("FAIL w_first_bcount got %0d want 1", cnt);
    end
    // AW three cycles ahead of W
    awaddr = 4'hC; awvalid = 1'b1;
    @(posedge aclk); #1; awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({awready, wready, bvalid} !== 3'b010) begin
        tests_failed++; $display("FAIL aw_first_wait%0d awready,wready,bvalid=%b want 010", i, {awready, wready, bvalid});
      end
      if (i < 2) begin @(posedge aclk); #1; end
    end
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1; wvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || reg3_o !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL aw_first_commit bvalid=%b reg3=%h want 1 CAFEF00D", bvalid, reg3_o);
    end
    cnt = 1; bready = 1'b1;
    repeat (4) begin @(posedge aclk); #1; if (bvalid) cnt++; end
    bready = 1'b0;
    tests_run++;
    if (cnt != 1) begin
      tests_failed++; $display("FAIL aw_first_bcount got %0d want 1", cnt);
    end
  endtask

  task automatic test_backpressure();
    awaddr = 4'h4; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1; wvalid = 1'b0;
    awaddr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({bvalid, awready, wready} !== 3'b100 || bresp !== 2'b00) begin
        tests_failed++; $display("FAIL b_stall%0d bvalid,awready,wready=%b bresp=%b want 100 00", i, {bvalid, awready, wready}, bresp);
      end
      @(posedge aclk); #1;
    end
    awvalid = 1'b0;
    tests_run++;
    if (reg1_o !== 32'h5A5A5A5A || reg0_o !== 32'd1) begin
      tests_failed++; $display("FAIL b_stall_regs reg1=%h reg0=%h want 5A5A5A5A 1", reg1_o, reg0_o);
    end
    bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL b_release bvalid=%b want 0", bvalid);
    end
    araddr = 4'h4; arvalid = 1'b1;
    @(posedge aclk); #1;
    araddr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({rvalid, arready} !== 2'b10 || rdata !== 32'h5A5A5A5A) begin
        tests_failed++; $display("FAIL r_stall%0d rvalid,arready=%b rdata=%h want 10 5A5A5A5A", i, {rvalid, arready}, rdata);
      end
      @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    rready = 1'b1; @(posedge aclk); #1; rready = 1'b0;
    tests_run++;
    if (rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL r_release rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_same_cycle();
    logic        ok;
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    do_write(4'h8, 32'h3, 4'hF, ok, resp, lat);
    araddr = 4'h8; arvalid = 1'b1;
    awaddr = 4'h8; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tests_run++;
    if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'h3 || reg2_o !== 32'h99) begin
      tests_failed++;
      $display("FAIL same_cycle rvalid,bvalid=%b rdata=%h reg2=%h want 11 3 99", {rvalid, bvalid}, rdata, reg2_o);
    end
    rready = 1'b1; bready = 1'b1; @(posedge aclk); #1; rready = 1'b0; bready = 1'b0;
    do_read(4'h8, ok, d, resp, lat);
    tests_run++;
    if (!ok || d !== 32'h99) begin
      tests_failed++; $display("FAIL same_cycle_reread ok=%b rdata=%h want 99", ok, d);
    end
  endtask

  task automatic test_reset_mid();
    logic        ok;
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1; awvalid = 1'b0; wvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || reg0_o !== 32'h5) begin
      tests_failed++; $display("FAIL mid_pre bvalid=%b reg0=%h want 1 5", bvalid, reg0_o);
    end
    aresetn = 1'b0; #1;
    tests_run++;
    if ({bvalid, awready, reg0_o} !== 34'h0) begin
      tests_failed++; $display("FAIL mid_async bvalid=%b awready=%b reg0=%h want 0 0 0", bvalid, awready, reg0_o);
    end
    @(posedge aclk); #1; aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(4'h0, ok, d, resp, lat);
    tests_run++;
    if (!ok || d !== 32'h0) begin
      tests_failed++; $display("FAIL mid_readback ok=%b rdata=%h want 0", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_split_channels();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite responder that implements a bank of four 32-bit read/write registers. It is the slave end of the S00_AXI bus that the master VIP drives. It accepts single-beat writes and reads, honours byte strobes, and always returns OKAY. All four register values are exported for use by downstream user logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; register select is ADDR[3:2].

Ports:
- S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg0_o..reg3_o  out  32 each  current register contents.

## Operation
Write FSM has three states: W_IDLE, W_WAIT, W_RESP.
- **W_IDLE:** AWREADY=1 and WREADY=1. Capture AW and W independently on their handshakes.
  - If both are captured in the same cycle, commit the write and go to W_RESP.
  - If only one is captured, go to W_WAIT.
- **W_WAIT:** deassert READY on the channel already captured. Keep READY=1 on the missing channel. When that channel handshakes, commit the write and go to W_RESP.
- **Commit:** reg[AWADDR[3:2]] byte k ← WDATA byte k for each k where WSTRB[k]=1. Bytes with WSTRB[k]=0 are unchanged. AWADDR[1:0] is ignored.
- **W_RESP:** BVALID=1, AWREADY=0, WREADY=0. On BVALID&&BREADY go to W_IDLE.
- At most one write is outstanding.

Read FSM has two states: R_IDLE and R_DATA.
- **R_IDLE:** ARREADY=1. On ARVALID, latch RDATA ← reg[ARADDR[3:2]], set RVALID=1, go to R_DATA.
- **R_DATA:** ARREADY=0. Hold RDATA and RVALID until RREADY. On RVALID&&RREADY go to R_IDLE.

Rules common to both paths:
- Read and write paths are fully independent and may be active in the same cycle.
- If a read is latched in the same cycle as a write commit to the same register, RDATA carries the pre-write value.
- All addresses decode; there is no SLVERR. Byte addresses 0x0, 0x4, 0x8 and 0xC select reg0..reg3.

## Timing
Reset (S_AXI_ARESETN=0, asynchronous) sets:
- all registers to 0;
- AWREADY, WREADY, ARREADY, BVALID and RVALID to 0;
- RDATA to 0; BRESP and RRESP to 0;
- both FSMs to idle.

After reset:
- READY signals rise on the first rising edge after ARESETN deasserts, so the first handshake is possible in cycle 2.
- Write: commit and BVALID are registered. BVALID asserts 1 cycle after the completing AW/W handshake.
- reg*_o reflects the new value in the same cycle that BVALID rises.
- Read: RVALID asserts 1 cycle after the AR handshake.
- With READY held high, sustained throughput is 1 write per 2 cycles and 1 read per 2 cycles.

Handshake rules:
- VALID outputs never drop without a handshake.
- RDATA and BRESP are stable while VALID is high.
- READY outputs do not depend combinationally on VALID inputs.

Reset mid-transaction abandons the outstanding response. BVALID/RVALID drop immediately and captured AW/W are discarded.

## Test plan
- Reset then write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read back -> RDATA = 1, 2, 3, 4; BRESP and RRESP are 0; reg0_o..reg3_o = 1..4.
- Write 0xAABBCCDD to 0x4, then write 0x11223344 with WSTRB=0x5 -> read 0x4 returns 0xAA22CC44.
- Present W three cycles before AW, then AW three cycles before W -> both commit correctly, exactly one BVALID each, and WREADY/AWREADY are 0 on the already-captured channel while waiting.
- Hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID, RVALID and RDATA are stable; no new AW or AR accepted until release.
- Same cycle: AR to 0x8 (holding 0x3) and write commit of 0x99 to 0x8 -> RDATA = 0x3, then a subsequent read returns 0x99.
- Assert ARESETN=0 while BVALID=1 after writing 0x5 to 0x0 -> BVALID drops immediately; after release a read of 0x0 returns 0.
